// File: rtl/trace_pkg.sv
// Shared types and constants for the commit trace encoder and its packet FIFO.
package trace_pkg;

    typedef enum logic [1:0] {
        KIND_REG   = 2'b00,
        KIND_LOAD  = 2'b01,
        KIND_STORE = 2'b10
    } trace_kind_t;

    typedef struct packed {
        logic [31:0] timestamp;
        logic [31:0] iaddress;
        logic [31:0] result;
        logic [31:0] address;
        logic [4:0]  destination;
        trace_kind_t kind;
    } trace_packet_t;

    localparam logic HEADER_SYNC = 1'b1;
    localparam int   REG_BYTES   = 13;
    localparam int   MEM_BYTES   = 17;

    function automatic logic [7:0] header_byte(input trace_packet_t p);
        return {HEADER_SYNC, p.kind, p.destination};
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous packet FIFO; full/empty are registered so they never depend on this cycle's push/pop.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  trace_packet_t data_i,
    input  logic          pop_i,
    output trace_packet_t data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    trace_packet_t mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, empty_q;
    logic          do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop)
            cnt_d = cnt_q + CNT_ONE;
        else if (!do_push && do_pop)
            cnt_d = cnt_q - CNT_ONE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == DEPTH_CNT);
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/commit_trace_encoder.sv
// Captures retired writebacks into trace packets and serializes them as a little-endian byte stream.
module commit_trace_encoder
    import trace_pkg::*;
#(
    parameter int FIFO_DEPTH      = 16,
    parameter int TIMESTAMP_WIDTH = 32
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        enable_i,
    input  logic        clear_i,
    input  logic        writeback_i,
    input  logic [31:0] wb_iaddress_i,
    input  logic [31:0] wb_result_i,
    input  logic [4:0]  wb_destination_i,
    input  logic        wb_load_i,
    input  logic        wb_store_i,
    input  logic [31:0] mem_address_i,
    input  logic [31:0] mem_data_i,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    input  logic        byte_ready_i,
    output logic        fifo_empty_o,
    output logic        overflow_o,
    output logic [15:0] dropped_count_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_TSTAMP, S_IADDR, S_RESULT, S_MEMADDR
    } state_t;

    localparam logic [TIMESTAMP_WIDTH-1:0] TS_ONE = TIMESTAMP_WIDTH'(1);
    // Every word field carries as many bytes as the trailing address field.
    localparam logic [1:0] LAST_IDX = 2'(MEM_BYTES - REG_BYTES - 1);

    logic [TIMESTAMP_WIDTH-1:0] ts_q;
    trace_packet_t wr_pkt, fifo_pkt, pkt_q, pkt_d;
    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic          fifo_full, fifo_empty, push, drop, pop, fire;
    logic          overflow_q;
    logic [15:0]   drop_cnt_q;
    logic [31:0]   word;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ts_q <= '0;
        else          ts_q <= ts_q + TS_ONE;
    end

    always_comb begin
        wr_pkt.timestamp   = 32'(ts_q);
        wr_pkt.iaddress    = wb_iaddress_i;
        wr_pkt.destination = wb_destination_i;
        wr_pkt.result      = wb_result_i;
        wr_pkt.address     = '0;
        wr_pkt.kind        = KIND_REG;
        if (wb_store_i) begin
            wr_pkt.kind    = KIND_STORE;
            wr_pkt.result  = mem_data_i;
            wr_pkt.address = mem_address_i;
        end else if (wb_load_i) begin
            wr_pkt.kind    = KIND_LOAD;
            wr_pkt.address = mem_address_i;
        end
    end

    assign push = writeback_i & enable_i & ~fifo_full;
    assign drop = writeback_i & enable_i & fifo_full;

    trace_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .data_i  (wr_pkt),
        .pop_i   (pop),
        .data_o  (fifo_pkt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A drop in the same cycle as clear_i must still be recorded.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (clear_i)                   drop_cnt_q <= 16'd1;
            else if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end else if (clear_i) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end
    end

    assign fire = byte_valid_o & byte_ready_i;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pkt_d   = pkt_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: if (!fifo_empty) begin
                pop     = 1'b1;
                pkt_d   = fifo_pkt;
                idx_d   = '0;
                state_d = S_HEADER;
            end
            S_HEADER: if (fire) state_d = S_TSTAMP;
            default: if (fire) begin
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    case (state_q)
                        S_TSTAMP: state_d = S_IADDR;
                        S_IADDR:  state_d = S_RESULT;
                        S_RESULT: state_d = (pkt_q.kind == KIND_REG) ? S_IDLE : S_MEMADDR;
                        default:  state_d = S_IDLE;
                    endcase
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pkt_q   <= pkt_d;
        end
    end

    always_comb begin
        word = '0;
        case (state_q)
            S_TSTAMP:  word = pkt_q.timestamp;
            S_IADDR:   word = pkt_q.iaddress;
            S_RESULT:  word = pkt_q.result;
            S_MEMADDR: word = pkt_q.address;
            default:   word = '0;
        endcase
        byte_o = (state_q == S_HEADER) ? header_byte(pkt_q) : word[{idx_q, 3'b000} +: 8];
    end

    assign byte_valid_o    = (state_q != S_IDLE);
    assign fifo_empty_o    = fifo_empty;
    assign overflow_o      = overflow_q;
    assign dropped_count_o = drop_cnt_q;

endmodule

// File: tb/tb_commit_trace_encoder.sv
// Directed bench for commit_trace_encoder: packet format, latency, backpressure, overflow, enable and reset.
module tb_commit_trace_encoder;

    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        enable_i = 1'b1, clear_i = 1'b0, writeback_i = 1'b0;
    logic [31:0] wb_iaddress_i = '0, wb_result_i = '0, mem_address_i = '0, mem_data_i = '0;
    logic [4:0]  wb_destination_i = '0;
    logic        wb_load_i = 1'b0, wb_store_i = 1'b0;
    logic [7:0]  byte_o;
    logic        byte_valid_o, byte_ready_i = 1'b1;
    logic        fifo_empty_o, overflow_o;
    logic [15:0] dropped_count_o;

    int total = 0, bad = 0;
    logic [31:0] tb_ts;
    logic [31:0] hdr_ts, ts0, ts1, pts;
    logic [31:0] ts_arr [20];
    logic [7:0]  rx[$], exp_q[$];
    bit          rx_wb = 1'b0, rx_en = 1'b1;

    always #5 clk = ~clk;

    // Reference cycle counter: zero in the first cycle after reset release.
    always @(posedge clk or negedge rst_n_i)
        if (!rst_n_i) tb_ts <= '0;
        else          tb_ts <= tb_ts + 32'd1;

    commit_trace_encoder #(.FIFO_DEPTH(16), .TIMESTAMP_WIDTH(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .enable_i(enable_i), .clear_i(clear_i),
        .writeback_i(writeback_i), .wb_iaddress_i(wb_iaddress_i), .wb_result_i(wb_result_i),
        .wb_destination_i(wb_destination_i), .wb_load_i(wb_load_i), .wb_store_i(wb_store_i),
        .mem_address_i(mem_address_i), .mem_data_i(mem_data_i),
        .byte_o(byte_o), .byte_valid_o(byte_valid_o), .byte_ready_i(byte_ready_i),
        .fifo_empty_o(fifo_empty_o), .overflow_o(overflow_o), .dropped_count_o(dropped_count_o)
    );

    task automatic set_wb(input bit v, input bit ld, input bit st, input logic [4:0] d,
                          input logic [31:0] ia, input logic [31:0] res,
                          input logic [31:0] ma, input logic [31:0] md);
        writeback_i = v; wb_load_i = ld; wb_store_i = st; wb_destination_i = d;
        wb_iaddress_i = ia; wb_result_i = res; mem_address_i = ma; mem_data_i = md;
    endtask

    task automatic make_exp(input logic [1:0] kind, input logic [4:0] d, input logic [31:0] ts,
                            input logic [31:0] ia, input logic [31:0] res, input logic [31:0] ma);
        exp_q.delete();
        exp_q.push_back({1'b1, kind, d});
        for (int k = 0; k < 4; k++) exp_q.push_back(ts[8*k +: 8]);
        for (int k = 0; k < 4; k++) exp_q.push_back(ia[8*k +: 8]);
        for (int k = 0; k < 4; k++) exp_q.push_back(res[8*k +: 8]);
        if (kind != 2'b00)
            for (int k = 0; k < 4; k++) exp_q.push_back(ma[8*k +: 8]);
    endtask

    // Appends accepted bytes to rx until the packet (or stop_at bytes) is complete.
    task automatic recv(input bit rnd, input int stop_at);
        int need, cyc;
        logic [7:0] last_b;
        bit stalled;
        need = 0; cyc = 0; last_b = '0; stalled = 1'b0;
        forever begin
            @(negedge clk);
            writeback_i = rx_wb; enable_i = rx_en;
            byte_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stalled) begin
                total++;
                if (byte_o !== last_b || byte_valid_o !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_stable: byte_o=%h valid=%b required byte_o=%h valid=1",
                             byte_o, byte_valid_o, last_b);
                end
            end
            if (byte_valid_o === 1'b1 && byte_ready_i) begin
                rx.push_back(byte_o);
                if (rx.size() == 1) hdr_ts = tb_ts;
                stalled = 1'b0;
            end else begin
                stalled = (byte_valid_o === 1'b1);
            end
            last_b = byte_o;
            if (rx.size() > 0) need = (rx[0][6:5] == 2'b00) ? 13 : 17;
            if (stop_at > 0 && rx.size() >= stop_at) break;
            if (need > 0 && rx.size() >= need) break;
            cyc++;
            if (cyc > 400) begin
                total++; bad++;
                $display("FAIL recv_timeout: got %0d bytes required %0d", rx.size(), need);
                break;
            end
        end
    endtask

    task automatic check_rx(input string name);
        int diff;
        diff = -1;
        total++;
        if (rx.size() == exp_q.size()) begin
            for (int i = 0; i < rx.size(); i++)
                if (diff < 0 && rx[i] !== exp_q[i]) diff = i;
        end else begin
            diff = 0;
        end
        if (diff >= 0) begin
            bad++;
            $display("FAIL %s: len=%0d byte[%0d]=%h required len=%0d byte=%h", name, rx.size(), diff,
                     (diff < rx.size()) ? rx[diff] : 8'hxx, exp_q.size(),
                     (diff < exp_q.size()) ? exp_q[diff] : 8'hxx);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        total++; if (byte_o !== 8'h00) begin bad++; $display("FAIL rst_byte: got %h required 00", byte_o); end
        total++; if (byte_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b required 0", byte_valid_o); end
        total++; if (fifo_empty_o !== 1'b1) begin bad++; $display("FAIL rst_empty: got %b required 1", fifo_empty_o); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b required 0", overflow_o); end
        total++; if (dropped_count_o !== 16'd0) begin bad++; $display("FAIL rst_drop: got %0d required 0", dropped_count_o); end
        @(negedge clk);
        rst_n_i = 1'b1;
    endtask

    task automatic test_reg;
        byte_ready_i = 1'b1;
        repeat (10) @(negedge clk);
        set_wb(1, 0, 0, 5'd5, 32'h100, 32'hDEADBEEF, 32'h0, 32'h0);
        rx.delete();
        recv(0, 0);
        total++; if (hdr_ts !== 32'd12) begin bad++; $display("FAIL reg_latency: header cycle %0d required 12", hdr_ts); end
        exp_q = '{8'h85, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        check_rx("reg_packet");
        @(negedge clk); #1;
        total++; if (byte_valid_o !== 1'b0) begin bad++; $display("FAIL reg_after: valid=%b required 0", byte_valid_o); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        set_wb(1, 1, 0, 5'd10, 32'h204, 32'h11223344, 32'h2000_0040, 32'h55);
        ts0 = tb_ts;
        @(negedge clk);
        set_wb(1, 1, 1, 5'd0, 32'h208, 32'h99, 32'h3000_0008, 32'hCAFEF00D);
        ts1 = tb_ts;
        rx.delete();
        recv(0, 0);
        make_exp(2'b01, 5'd10, ts0, 32'h204, 32'h11223344, 32'h2000_0040);
        check_rx("load_packet");
        total++;
        if (rx.size() != 17 || rx[0] !== 8'hAA || rx[13] !== 8'h40 || rx[14] !== 8'h00 ||
            rx[15] !== 8'h00 || rx[16] !== 8'h20) begin
            bad++; $display("FAIL load_fields: len=%0d hdr=%h required len=17 hdr=AA tail=40000020", rx.size(), rx[0]);
        end
        @(negedge clk); #1;
        total++; if (byte_valid_o !== 1'b0 || fifo_empty_o !== 1'b0) begin
            bad++; $display("FAIL b2b_idle: valid=%b empty=%b required 0 0", byte_valid_o, fifo_empty_o);
        end
        rx.delete();
        recv(0, 0);
        make_exp(2'b10, 5'd0, ts1, 32'h208, 32'hCAFEF00D, 32'h3000_0008);
        check_rx("store_packet");
        total++; if (rx[0] !== 8'hC0) begin bad++; $display("FAIL store_hdr: got %h required C0", rx[0]); end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        set_wb(1, 0, 1, 5'd31, 32'h0000_ABCC, 32'h1, 32'h7654_3210, 32'h0BAD_F00D);
        ts0 = tb_ts;
        rx.delete();
        recv(1, 0);
        make_exp(2'b10, 5'd31, ts0, 32'h0000_ABCC, 32'h0BAD_F00D, 32'h7654_3210);
        check_rx("bp_packet");
        byte_ready_i = 1'b1;
        @(negedge clk); #1;
        total++; if (byte_valid_o !== 1'b0) begin bad++; $display("FAIL bp_after: valid=%b required 0", byte_valid_o); end
    endtask

    task automatic test_overflow;
        @(negedge clk);
        byte_ready_i = 1'b0;
        set_wb(1, 0, 0, 5'd1, 32'h300, 32'h77, 32'h0, 32'h0);
        pts = tb_ts;
        @(negedge clk);
        set_wb(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            set_wb(1, 0, 0, 5'(i), 32'h1000 + 32'(4 * i), 32'hA500_0000 + 32'(i), 32'h0, 32'h0);
            ts_arr[i] = tb_ts;
            @(negedge clk);
        end
        set_wb(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        total++; if (dropped_count_o !== 16'd4 || overflow_o !== 1'b1) begin
            bad++; $display("FAIL ovf_count: dropped=%0d ovf=%b required 4 1", dropped_count_o, overflow_o);
        end
        total++; if (byte_valid_o !== 1'b1 || byte_o !== 8'h81) begin
            bad++; $display("FAIL ovf_stall: valid=%b byte=%h required 1 81", byte_valid_o, byte_o);
        end
        @(negedge clk);
        clear_i = 1'b1;
        set_wb(1, 0, 0, 5'd30, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        clear_i = 1'b0;
        set_wb(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        total++; if (dropped_count_o !== 16'd1 || overflow_o !== 1'b1) begin
            bad++; $display("FAIL clear_vs_drop: dropped=%0d ovf=%b required 1 1", dropped_count_o, overflow_o);
        end
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        #1;
        total++; if (dropped_count_o !== 16'd0 || overflow_o !== 1'b0) begin
            bad++; $display("FAIL clear: dropped=%0d ovf=%b required 0 0", dropped_count_o, overflow_o);
        end
        rx.delete();
        recv(0, 0);
        make_exp(2'b00, 5'd1, pts, 32'h300, 32'h77, 32'h0);
        check_rx("ovf_pilot");
        for (int i = 0; i < 16; i++) begin
            rx.delete();
            recv(0, 0);
            make_exp(2'b00, 5'(i), ts_arr[i], 32'h1000 + 32'(4 * i), 32'hA500_0000 + 32'(i), 32'h0);
            check_rx($sformatf("ovf_drain%0d", i));
        end
        @(negedge clk); #1;
        total++; if (fifo_empty_o !== 1'b1 || byte_valid_o !== 1'b0) begin
            bad++; $display("FAIL ovf_drained: empty=%b valid=%b required 1 0", fifo_empty_o, byte_valid_o);
        end
    endtask

    task automatic test_enable;
        byte_ready_i = 1'b1;
        enable_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_wb(1, 0, 0, 5'(i), 32'h40, 32'h41, 32'h0, 32'h0);
            #1;
            total++; if (fifo_empty_o !== 1'b1 || byte_valid_o !== 1'b0) begin
                bad++; $display("FAIL en_off%0d: empty=%b valid=%b required 1 0", i, fifo_empty_o, byte_valid_o);
            end
        end
        @(negedge clk);
        set_wb(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        total++; if (fifo_empty_o !== 1'b1 || dropped_count_o !== 16'd0) begin
            bad++; $display("FAIL en_off_end: empty=%b dropped=%0d required 1 0", fifo_empty_o, dropped_count_o);
        end
        enable_i = 1'b1;
        set_wb(1, 1, 0, 5'd3, 32'h400, 32'h1234, 32'h8, 32'h0);
        ts0 = tb_ts;
        rx.delete();
        recv(0, 5);
        rx_en = 1'b0; rx_wb = 1'b1;
        recv(0, 0);
        make_exp(2'b01, 5'd3, ts0, 32'h400, 32'h1234, 32'h8);
        check_rx("en_midpacket");
        @(negedge clk); #1;
        total++; if (fifo_empty_o !== 1'b1 || byte_valid_o !== 1'b0 || dropped_count_o !== 16'd0) begin
            bad++; $display("FAIL en_after: empty=%b valid=%b dropped=%0d required 1 0 0",
                            fifo_empty_o, byte_valid_o, dropped_count_o);
        end
        rx_en = 1'b1; rx_wb = 1'b0;
        enable_i = 1'b1;
        set_wb(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid;
        byte_ready_i = 1'b1;
        @(negedge clk);
        set_wb(1, 1, 0, 5'd7, 32'h700, 32'h701, 32'h702, 32'h0);
        @(negedge clk);
        set_wb(1, 0, 0, 5'd8, 32'h800, 32'h801, 32'h0, 32'h0);
        rx.delete();
        recv(0, 7);
        @(negedge clk);
        #2 rst_n_i = 1'b0;
        #1;
        total++; if (byte_valid_o !== 1'b0 || byte_o !== 8'h00 || fifo_empty_o !== 1'b1) begin
            bad++; $display("FAIL midrst_out: valid=%b byte=%h empty=%b required 0 00 1", byte_valid_o, byte_o, fifo_empty_o);
        end
        @(negedge clk);
        rst_n_i = 1'b1;
        #1;
        total++; if (fifo_empty_o !== 1'b1 || byte_valid_o !== 1'b0) begin
            bad++; $display("FAIL midrst_release: empty=%b valid=%b required 1 0", fifo_empty_o, byte_valid_o);
        end
        repeat (3) @(negedge clk);
        set_wb(1, 0, 0, 5'd2, 32'h500, 32'h600, 32'h0, 32'h0);
        rx.delete();
        recv(0, 0);
        make_exp(2'b00, 5'd2, 32'd3, 32'h500, 32'h600, 32'h0);
        check_rx("midrst_next");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_reg;
        test_back_to_back;
        test_backpressure;
        test_overflow;
        test_enable;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
